// File: rtl/iiitb_wb_trace.sv
// Wishbone-readable trace FIFO that records every change of the core write-back value.
// Optional build macro WB_TRACE_TIMESTAMP_EN tags each entry with a 16-bit cycle stamp.
module iiitb_wb_trace #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        RN,
    input  logic [15:0] WB_OUT,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        trace_irq
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
`ifdef WB_TRACE_TIMESTAMP_EN
    localparam int unsigned EW = 32;
`else
    localparam int unsigned EW = 16;
`endif

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [15:0]   prev, prev_nxt;
    logic          en, ie, ovf;
    logic          en_nxt, ie_nxt, ovf_nxt;
    logic [31:0]   dat_nxt;
    logic [EW-1:0] entry;
    logic [1:0]    reg_sel;
    logic          req, rd_req, wr_req;
    logic          pop, push, clr, cap, drop, st_clr, full, empty;

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [15:0] ts;

    // Free-running stamp; wraps naturally at 16 bits
    always_ff @(posedge clk or posedge RN) begin
        if (RN) ts <= '0;
        else    ts <= ts + 16'd1;
    end

    assign entry = {ts, WB_OUT};
`else
    assign entry = WB_OUT;
`endif

    // Only adr[3:2], dat[10] and dat[2:0] carry meaning; byte selects are ignored
    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0],
                           wbs_dat_i[31:11], wbs_dat_i[9:3]};

    assign reg_sel = wbs_adr_i[3:2];
    assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign rd_req  = req & ~wbs_we_i;
    assign wr_req  = req & wbs_we_i;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    // All register side effects land on the request edge so they are visible in the ack cycle
    assign pop    = rd_req & (reg_sel == A_DATA) & ~empty;
    assign clr    = wr_req & (reg_sel == A_CTRL) & wbs_dat_i[2];
    assign st_clr = wr_req & (reg_sel == A_STATUS) & wbs_dat_i[10];
    assign cap    = en & (WB_OUT != prev);
    assign push   = cap & ~clr & (~full | pop);
    assign drop   = cap & ~clr & full & ~pop;

    always_comb begin
        count_nxt  = count + CW'(push) - CW'(pop);
        rd_ptr_nxt = rd_ptr + AW'(pop);
        wr_ptr_nxt = wr_ptr + AW'(push);
        prev_nxt   = cap ? WB_OUT : prev;
        ovf_nxt    = drop | (ovf & ~st_clr);
        en_nxt     = en;
        ie_nxt     = ie;
        if (wr_req && reg_sel == A_CTRL) begin
            en_nxt = wbs_dat_i[0];
            ie_nxt = wbs_dat_i[1];
        end
        if (clr) begin
            count_nxt  = '0;
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
            prev_nxt   = '0;
            ovf_nxt    = 1'b0;
        end
    end

    // Read mux; writes and idle cycles return zero
    always_comb begin
        dat_nxt = '0;
        if (rd_req) begin
            case (reg_sel)
                A_DATA:   dat_nxt = empty ? 32'd0 : 32'(mem[rd_ptr]);
                A_STATUS: dat_nxt = {21'd0, ovf, full, empty, 2'd0, 6'(count)};
                A_CTRL:   dat_nxt = {30'd0, ie, en};
                default:  dat_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            prev      <= '0;
            en        <= 1'b0;
            ie        <= 1'b0;
            ovf       <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            trace_irq <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr_nxt;
            wr_ptr    <= wr_ptr_nxt;
            count     <= count_nxt;
            prev      <= prev_nxt;
            en        <= en_nxt;
            ie        <= ie_nxt;
            ovf       <= ovf_nxt;
            wbs_ack_o <= req;
            wbs_dat_o <= dat_nxt;
            trace_irq <= (count_nxt != '0) & ie_nxt;
        end
    end

endmodule

// File: tb/tb_iiitb_wb_trace.sv
// Bench for iiitb_wb_trace: queue-based reference model checked every cycle, plus directed literal checks.
module tb_iiitb_wb_trace;

    localparam int unsigned DEPTH = 8;

    logic        clk    = 1'b0;
    logic        rn     = 1'b1;
    logic [15:0] wb_out = '0;
    logic        cyc    = 1'b0;
    logic        stb    = 1'b0;
    logic        we     = 1'b0;
    logic [31:0] adr    = '0;
    logic [31:0] dat    = '0;
    logic [3:0]  sel    = 4'hF;
    logic        ack;
    logic [31:0] dat_o;
    logic        irq;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] q[$];
    logic [15:0] m_prev = '0;
    logic        m_en   = 1'b0;
    logic        m_ie   = 1'b0;
    logic        m_ovf  = 1'b0;
    logic        m_ack  = 1'b0;
    logic        m_irq  = 1'b0;
    logic [31:0] m_dat  = '0;
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [15:0] m_ts   = '0;
`endif

    iiitb_wb_trace #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .RN        (rn),
        .WB_OUT    (wb_out),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_sel_i (sel),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .trace_irq (irq)
    );

    always #5 clk = ~clk;

    // Model: one step per cycle, from the register-map rules
    always @(posedge clk or posedge rn) begin
        logic        req;
        logic        cap;
        logic        clr;
        logic [31:0] rd;
        logic [31:0] ent;
        if (rn) begin
            q.delete();
            m_prev = '0; m_en = 1'b0; m_ie = 1'b0; m_ovf = 1'b0;
            m_ack = 1'b0; m_dat = '0; m_irq = 1'b0;
`ifdef WB_TRACE_TIMESTAMP_EN
            m_ts = '0;
`endif
        end else begin
            req = cyc & stb & ~m_ack;
            cap = m_en && (wb_out != m_prev);
            clr = 1'b0;
            rd  = '0;
`ifdef WB_TRACE_TIMESTAMP_EN
            ent = {m_ts, wb_out};
`else
            ent = {16'd0, wb_out};
`endif
            if (req) begin
                case (adr[3:2])
                    2'd0: if (!we && q.size() != 0) rd = q.pop_front();
                    2'd1: if (we) begin
                              if (dat[10]) m_ovf = 1'b0;
                          end else begin
                              rd = {21'd0, m_ovf, q.size() == DEPTH, q.size() == 0, 2'd0, 6'(q.size())};
                          end
                    2'd2: if (we) begin
                              m_en = dat[0]; m_ie = dat[1]; clr = dat[2];
                          end else begin
                              rd = {30'd0, m_ie, m_en};
                          end
                    default: rd = '0;
                endcase
            end
            if (clr) begin
                q.delete(); m_prev = '0; m_ovf = 1'b0;
            end else if (cap) begin
                m_prev = wb_out;
                if (q.size() < DEPTH) q.push_back(ent);
                else m_ovf = 1'b1;
            end
            m_ack = req;
            m_dat = rd;
            m_irq = m_ie && (q.size() != 0);
`ifdef WB_TRACE_TIMESTAMP_EN
            m_ts = m_ts + 16'd1;
`endif
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        total++;
        if ({ack, irq, dat_o} !== {m_ack, m_irq, m_dat}) begin
            bad++;
            $display("FAIL cycle_model t=%0t got ack=%b irq=%b dat=%h want ack=%b irq=%b dat=%h",
                     $time, ack, irq, dat_o, m_ack, m_irq, m_dat);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic chg, input logic [15:0] v, output logic [31:0] r);
        int n;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = {28'd0, a, 2'b00}; dat = d;
        if (chg) wb_out = v;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack !== 1'b1 && n < 8);
        chk("ack_seen", {31'd0, ack}, 32'd1);
        r = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] r);
        bus(1'b0, a, 32'd0, 1'b0, 16'd0, r);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b1, a, d, 1'b0, 16'd0, r);
    endtask

    task automatic drive_wb(input logic [15:0] v);
        @(posedge clk); #1;
        wb_out = v;
    endtask

    initial begin
        logic [31:0] r;
`ifdef WB_TRACE_TIMESTAMP_EN
        logic [31:0] r2;
        logic [15:0] ta;
`endif
        repeat (3) @(posedge clk);
        #1 rn = 1'b0;

        rd(2'd1, r); chk("status_reset", r, 32'h100);
        rd(2'd2, r); chk("ctrl_reset", r, 32'h0);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, r); chk("addr3_read", r, 32'h0);
        wr(2'd2, 32'h1);
        rd(2'd2, r); chk("ctrl_en", r, 32'h1);

        // Change capture: 0 (same as reset PREV), 0x1234 held, then 0xBEEF
        drive_wb(16'h0000);
        drive_wb(16'h1234);
        repeat (5) @(posedge clk);
        drive_wb(16'hBEEF);
        @(posedge clk);
        rd(2'd1, r); chk("status_two", r, 32'h002);
        rd(2'd0, r); chk("data_1234", {16'd0, r[15:0]}, 32'h1234);
`ifndef WB_TRACE_TIMESTAMP_EN
        chk("data_hi_zero", {16'd0, r[31:16]}, 32'h0);
`endif
        rd(2'd0, r); chk("data_beef", {16'd0, r[15:0]}, 32'hBEEF);
        rd(2'd0, r); chk("data_empty", r, 32'h0);

        // Overflow: 10 values into 8 entries
        for (int i = 1; i <= 10; i++) drive_wb(16'(i));
        @(posedge clk);
        rd(2'd1, r); chk("status_ovf", r, 32'h608);
        for (int i = 1; i <= 8; i++) begin
            rd(2'd0, r); chk("data_ovf_order", {16'd0, r[15:0]}, 32'(i));
        end
        wr(2'd1, 32'h400);
        rd(2'd1, r); chk("status_ovf_clr", r, 32'h100);

        // Full FIFO: pop and push in the same cycle
        for (int i = 0; i < 8; i++) drive_wb(16'h0011 + 16'(i));
        @(posedge clk);
        rd(2'd1, r); chk("status_full", r, 32'h208);
        bus(1'b0, 2'd0, 32'd0, 1'b1, 16'h0099, r);
        chk("data_full_pop", {16'd0, r[15:0]}, 32'h0011);
        rd(2'd1, r); chk("status_full_keep", r, 32'h208);
        for (int i = 1; i < 8; i++) begin
            rd(2'd0, r); chk("data_full_order", {16'd0, r[15:0]}, 32'h0011 + 32'(i));
        end
        rd(2'd0, r); chk("data_new_last", {16'd0, r[15:0]}, 32'h0099);
        rd(2'd1, r); chk("status_drained", r, 32'h100);

        // CLR in the same cycle as a capture
        bus(1'b1, 2'd2, 32'h4, 1'b1, 16'h00AA, r);
        rd(2'd1, r); chk("status_clr", r, 32'h100);
        wr(2'd2, 32'h1);
        @(posedge clk);
        rd(2'd1, r); chk("status_recap", r, 32'h001);
        rd(2'd0, r); chk("data_recap", {16'd0, r[15:0]}, 32'h00AA);

        // Interrupt, then reset in the middle of an access
        wr(2'd2, 32'h3);
        drive_wb(16'h0101);
        drive_wb(16'h0102);
        drive_wb(16'h0103);
        @(posedge clk);
        @(negedge clk); chk("irq_on", {31'd0, irq}, 32'd1);
        rd(2'd1, r); chk("status_three", r, 32'h003);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4;
        @(negedge clk); #2 rn = 1'b1;
        @(negedge clk);
        chk("rst_no_ack", {31'd0, ack}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_dat", dat_o, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        #1 rn = 1'b0;
        rd(2'd1, r); chk("status_after_rst", r, 32'h100);
        @(negedge clk); chk("irq_after_rst", {31'd0, irq}, 32'd0);

`ifdef WB_TRACE_TIMESTAMP_EN
        // Two captures exactly 65536 cycles apart carry the same stamp
        wr(2'd2, 32'h1);
        drive_wb(16'h0500);
        ta = m_ts;
        repeat (65535) @(posedge clk);
        drive_wb(16'h0600);
        @(posedge clk);
        rd(2'd0, r);
        rd(2'd0, r2);
        chk("ts_first", {16'd0, r[31:16]}, {16'd0, ta});
        chk("ts_wrapped", {16'd0, r2[31:16]}, {16'd0, ta});
        chk("ts_val2", {16'd0, r2[15:0]}, 32'h0600);
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iiitb_wb_trace.md
IIITB_WB_TRACE -- requirements
Module: iiitb_wb_trace

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO entry count; legal values are powers of two from 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, connected to wb_clk_i.
REQ-003 The block SHALL have port RN, input, 1 bit: reset, asynchronous and active-high, connected to wb_rst_i.
REQ-004 The block SHALL have port WB_OUT, input, 16 bits: the core write-back value, from iiitb_rv32i WB_OUT.
REQ-005 The block SHALL have ports wbs_cyc_i, wbs_stb_i and wbs_we_i, each an input of 1 bit: the Wishbone classic cycle, strobe and write enable.
REQ-006 The block SHALL have port wbs_adr_i, input, 32 bits: the byte address; only bits [3:2] are decoded.
REQ-007 The block SHALL have port wbs_dat_i, input, 32 bits: write data.
REQ-008 The block SHALL have port wbs_sel_i, input, 4 bits: byte selects; these are ignored and every access is treated as full-word.
REQ-009 The block SHALL have port wbs_ack_o, output, 1 bit: the Wishbone acknowledge.
REQ-010 The block SHALL have port wbs_dat_o, output, 32 bits: read data.
REQ-011 The block SHALL have port trace_irq, output, 1 bit: high while the FIFO is non-empty and CTRL.IE=1; it is routed to user_irq[0].

Function
REQ-012 Capture: in each cycle where CTRL.EN=1 and WB_OUT differs from the 16-bit register PREV, the block SHALL load PREV with WB_OUT and push WB_OUT into the FIFO.
REQ-013 When CTRL.EN=0, the block SHALL NOT update PREV and SHALL NOT push.
REQ-014 When a push is attempted while the FIFO is full, the entry SHALL be dropped, PREV SHALL still update, and sticky STATUS.OVF SHALL be set.
REQ-015 A request SHALL be defined as wbs_cyc_i & wbs_stb_i & ~wbs_ack_o.
REQ-016 For each request, wbs_ack_o SHALL assert for exactly one cycle, in the cycle following the request; back-to-back requests therefore get an ack every second cycle.
REQ-017 wbs_dat_o SHALL be valid in the ack cycle and SHALL be 0 in all other cycles.
REQ-018 adr[3:2]=0 (DATA, read-only): a read SHALL return the FIFO head in [15:0] and pop it in the ack cycle; a read while empty SHALL return 0 and change no state.
REQ-019 adr[3:2]=1 (STATUS, read-only): the block SHALL return [5:0]=COUNT, [8]=EMPTY, [9]=FULL and [10]=OVF.
REQ-020 adr[3:2]=1 (STATUS): a write with wbs_dat_i[10]=1 SHALL clear OVF.
REQ-021 adr[3:2]=2 (CTRL, read/write): bit0=EN, bit1=IE, and bit2=CLR, which is write-only and self-clearing; a read SHALL return {IE,EN} with bit2 reading 0.
REQ-022 A CLR write SHALL empty the FIFO, clear OVF and reset PREV to 0 in the ack cycle.
REQ-023 adr[3:2]=3: a read SHALL return 0, a write SHALL be ignored, and the access SHALL still be acknowledged.
REQ-024 When a push and a DATA pop occur in the same cycle, both SHALL take effect: COUNT stays unchanged, the head is returned, and the new entry is appended; this also applies when the FIFO is full.
REQ-025 When a push and CLR occur in the same cycle, CLR SHALL win: the FIFO ends empty and PREV ends 0.
REQ-026 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; COUNT SHALL range from 0 to DEPTH.

Reset
REQ-027 While RN=1, and immediately on its assertion, the block SHALL force FIFO empty, COUNT=0, OVF=0, PREV=0, EN=0, IE=0, wbs_ack_o=0, wbs_dat_o=0 and trace_irq=0.
REQ-028 An access in flight when RN asserts SHALL be abandoned with no ack; the first request after RN deasserts SHALL be acknowledged normally.

Configuration
REQ-029 With WB_TRACE_TIMESTAMP_EN defined, the block SHALL contain a 16-bit free-running cycle counter that is reset to 0, increments every cycle, and wraps from 0xFFFF to 0.
REQ-030 With WB_TRACE_TIMESTAMP_EN defined, each FIFO entry SHALL store the counter value of its push cycle, and a DATA read SHALL return that value in [31:16].
REQ-031 With WB_TRACE_TIMESTAMP_EN undefined, the counter SHALL be absent, entries SHALL be 16 bits, and DATA[31:16] SHALL read 0.

Verification
REQ-032 Reset, write CTRL=1, drive WB_OUT 0x0000 then 0x1234 held for 5 cycles, then 0xBEEF -> COUNT=2; DATA reads return 0x1234 then 0xBEEF; a third read returns 0.
REQ-033 EN=1, DEPTH=8, drive 10 distinct values -> FULL=1 and OVF=1; reads return the first 8 values in order; writing STATUS with bit10=1 clears OVF.
REQ-034 With the FIFO full, issue a DATA read in the same cycle a new value arrives -> COUNT stays 8, OVF stays 0, and the new value is read last.
REQ-035 Write CTRL=0x4 in the same cycle as a capture -> EMPTY=1, and a following WB_OUT equal to the pre-clear value is captured again.
REQ-036 Assert RN mid-access with 3 entries queued -> no ack is issued, STATUS reads 0x100, and trace_irq=0.
REQ-037 With WB_TRACE_TIMESTAMP_EN defined, capture values at cycles 3 and 65539 after reset -> timestamps read 3 and 3 (counter wrapped); with the macro undefined, DATA[31:16]=0.
